// File: rtl/ysyx_041461_axi_pkg.sv
// Shared definitions for the CPU-side AXI4 router: FSM states, response codes,
// target selects and the default address map.
package ysyx_041461_axi_pkg;

   localparam int ID_W   = 4;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 64;
   localparam int STRB_W = 8;
   localparam int LEN_W  = 8;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] DECERR = 2'b11;

   localparam logic [31:0] CLINT_CMP_BASE_DEF  = 32'h0200_4000;
   localparam logic [31:0] CLINT_TIME_BASE_DEF = 32'h0200_bff8;
   localparam logic [31:0] MEM_BASE_DEF        = 32'h8000_0000;
   localparam logic [31:0] MEM_LIMIT_DEF       = 32'h87ff_ffff;

   typedef enum logic [3:0] {
      IDLE       = 4'd0,
      W_ADDR     = 4'd1,
      W_DATA     = 4'd2,
      W_RESP     = 4'd3,
      W_ERR_DATA = 4'd4,
      W_ERR_RESP = 4'd5,
      R_ADDR     = 4'd6,
      R_DATA     = 4'd7,
      R_ERR      = 4'd8
   } state_e;

   typedef enum logic [1:0] {
      TGT_CLINT = 2'd0,
      TGT_MEM   = 2'd1,
      TGT_ERR   = 2'd2
   } tgt_e;

   // Unsigned offset compare; an address below base wraps to a huge offset.
   function automatic logic in_window8(input logic [31:0] addr, input logic [31:0] base);
      logic [31:0] off;
      off = addr - base;
      return (off < 32'd8);
   endfunction

endpackage

// File: rtl/ysyx_041461_axi_addr_decode.sv
// Combinational address/len decoder selecting CLINT, memory or a local DECERR.
module ysyx_041461_axi_addr_decode
   import ysyx_041461_axi_pkg::*;
#(
   parameter logic [31:0] CLINT_CMP_BASE  = CLINT_CMP_BASE_DEF,
   parameter logic [31:0] CLINT_TIME_BASE = CLINT_TIME_BASE_DEF,
   parameter logic [31:0] MEM_BASE        = MEM_BASE_DEF,
   parameter logic [31:0] MEM_LIMIT       = MEM_LIMIT_DEF
) (
   input  logic [31:0] i_addr,
   input  logic [7:0]  i_len,
   output tgt_e        o_tgt
);

   logic w_clint_win;

   assign w_clint_win = in_window8(i_addr, CLINT_CMP_BASE) | in_window8(i_addr, CLINT_TIME_BASE);

   // The CLINT never accepts bursts, so a burst into its window is an error.
   always_comb begin
      o_tgt = TGT_ERR;
      if (w_clint_win) begin
         o_tgt = (i_len == 8'd0) ? TGT_CLINT : TGT_ERR;
      end else if ((i_addr >= MEM_BASE) && (i_addr <= MEM_LIMIT)) begin
         o_tgt = TGT_MEM;
      end
   end

endmodule

// File: rtl/ysyx_041461_axi_demux.sv
// Single-master, two-slave AXI4 router (CLINT / main memory), one transaction
// in flight; address phase registered, data and response channels muxed.
module ysyx_041461_axi_demux
   import ysyx_041461_axi_pkg::*;
#(
   parameter logic [31:0] CLINT_CMP_BASE  = CLINT_CMP_BASE_DEF,
   parameter logic [31:0] CLINT_TIME_BASE = CLINT_TIME_BASE_DEF,
   parameter logic [31:0] MEM_BASE        = MEM_BASE_DEF,
   parameter logic [31:0] MEM_LIMIT       = MEM_LIMIT_DEF
) (
   input  logic        clk,
   input  logic        rst,
   // CPU slave side
   input  logic        CPU_awvalid,
   output logic        CPU_awready,
   input  logic [3:0]  CPU_awid,
   input  logic [31:0] CPU_awaddr,
   input  logic [7:0]  CPU_awlen,
   input  logic [2:0]  CPU_awsize,
   input  logic [1:0]  CPU_awburst,
   input  logic        CPU_wvalid,
   output logic        CPU_wready,
   input  logic [63:0] CPU_wdata,
   input  logic [7:0]  CPU_wstrb,
   input  logic        CPU_wlast,
   input  logic        CPU_bready,
   output logic        CPU_bvalid,
   output logic [3:0]  CPU_bid,
   output logic [1:0]  CPU_bresp,
   input  logic        CPU_arvalid,
   output logic        CPU_arready,
   input  logic [3:0]  CPU_arid,
   input  logic [31:0] CPU_araddr,
   input  logic [7:0]  CPU_arlen,
   input  logic [2:0]  CPU_arsize,
   input  logic [1:0]  CPU_arburst,
   input  logic        CPU_rready,
   output logic        CPU_rvalid,
   output logic [3:0]  CPU_rid,
   output logic [1:0]  CPU_rresp,
   output logic [63:0] CPU_rdata,
   output logic        CPU_rlast,
   // CLINT master side
   output logic        CLINT_awvalid,
   input  logic        CLINT_awready,
   output logic [3:0]  CLINT_awid,
   output logic [31:0] CLINT_awaddr,
   output logic [7:0]  CLINT_awlen,
   output logic [2:0]  CLINT_awsize,
   output logic [1:0]  CLINT_awburst,
   output logic        CLINT_wvalid,
   input  logic        CLINT_wready,
   output logic [63:0] CLINT_wdata,
   output logic [7:0]  CLINT_wstrb,
   output logic        CLINT_wlast,
   output logic        CLINT_bready,
   input  logic        CLINT_bvalid,
   input  logic [3:0]  CLINT_bid,
   input  logic [1:0]  CLINT_bresp,
   output logic        CLINT_arvalid,
   input  logic        CLINT_arready,
   output logic [3:0]  CLINT_arid,
   output logic [31:0] CLINT_araddr,
   output logic [7:0]  CLINT_arlen,
   output logic [2:0]  CLINT_arsize,
   output logic [1:0]  CLINT_arburst,
   output logic        CLINT_rready,
   input  logic        CLINT_rvalid,
   input  logic [3:0]  CLINT_rid,
   input  logic [1:0]  CLINT_rresp,
   input  logic [63:0] CLINT_rdata,
   input  logic        CLINT_rlast,
   // Memory master side
   output logic        MEM_awvalid,
   input  logic        MEM_awready,
   output logic [3:0]  MEM_awid,
   output logic [31:0] MEM_awaddr,
   output logic [7:0]  MEM_awlen,
   output logic [2:0]  MEM_awsize,
   output logic [1:0]  MEM_awburst,
   output logic        MEM_wvalid,
   input  logic        MEM_wready,
   output logic [63:0] MEM_wdata,
   output logic [7:0]  MEM_wstrb,
   output logic        MEM_wlast,
   output logic        MEM_bready,
   input  logic        MEM_bvalid,
   input  logic [3:0]  MEM_bid,
   input  logic [1:0]  MEM_bresp,
   output logic        MEM_arvalid,
   input  logic        MEM_arready,
   output logic [3:0]  MEM_arid,
   output logic [31:0] MEM_araddr,
   output logic [7:0]  MEM_arlen,
   output logic [2:0]  MEM_arsize,
   output logic [1:0]  MEM_arburst,
   output logic        MEM_rready,
   input  logic        MEM_rvalid,
   input  logic [3:0]  MEM_rid,
   input  logic [1:0]  MEM_rresp,
   input  logic [63:0] MEM_rdata,
   input  logic        MEM_rlast
);

   state_e      r_state;
   state_e      w_next;
   tgt_e        r_tgt;
   tgt_e        w_aw_tgt;
   tgt_e        w_ar_tgt;
   logic [3:0]  r_id;
   logic [31:0] r_addr;
   logic [7:0]  r_len;
   logic [2:0]  r_size;
   logic [1:0]  r_burst;
   logic [7:0]  r_cnt;
   logic        w_to_clint;

   ysyx_041461_axi_addr_decode #(
      .CLINT_CMP_BASE (CLINT_CMP_BASE),
      .CLINT_TIME_BASE(CLINT_TIME_BASE),
      .MEM_BASE       (MEM_BASE),
      .MEM_LIMIT      (MEM_LIMIT)
   ) u_aw_dec (
      .i_addr(CPU_awaddr),
      .i_len (CPU_awlen),
      .o_tgt (w_aw_tgt)
   );

   ysyx_041461_axi_addr_decode #(
      .CLINT_CMP_BASE (CLINT_CMP_BASE),
      .CLINT_TIME_BASE(CLINT_TIME_BASE),
      .MEM_BASE       (MEM_BASE),
      .MEM_LIMIT      (MEM_LIMIT)
   ) u_ar_dec (
      .i_addr(CPU_araddr),
      .i_len (CPU_arlen),
      .o_tgt (w_ar_tgt)
   );

   assign w_to_clint = (r_tgt == TGT_CLINT);

   // AW wins over AR in IDLE because awready is unconditional there.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_tgt   <= TGT_CLINT;
         r_id    <= '0;
         r_addr  <= '0;
         r_len   <= '0;
         r_size  <= '0;
         r_burst <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         if ((r_state == IDLE) && CPU_awvalid) begin
            r_tgt   <= w_aw_tgt;
            r_id    <= CPU_awid;
            r_addr  <= CPU_awaddr;
            r_len   <= CPU_awlen;
            r_size  <= CPU_awsize;
            r_burst <= CPU_awburst;
         end else if ((r_state == IDLE) && CPU_arvalid) begin
            r_tgt   <= w_ar_tgt;
            r_id    <= CPU_arid;
            r_addr  <= CPU_araddr;
            r_len   <= CPU_arlen;
            r_size  <= CPU_arsize;
            r_burst <= CPU_arburst;
            r_cnt   <= CPU_arlen;
         end else if ((r_state == R_ERR) && CPU_rready && (r_cnt != 8'd0)) begin
            r_cnt <= r_cnt - 8'd1;
         end
      end
   end

   always_comb begin
      w_next        = r_state;
      CPU_awready   = 1'b0;
      CPU_wready    = 1'b0;
      CPU_bvalid    = 1'b0;
      CPU_bid       = '0;
      CPU_bresp     = '0;
      CPU_arready   = 1'b0;
      CPU_rvalid    = 1'b0;
      CPU_rid       = '0;
      CPU_rresp     = '0;
      CPU_rdata     = '0;
      CPU_rlast     = 1'b0;
      CLINT_awvalid = 1'b0;
      CLINT_awid    = '0;
      CLINT_awaddr  = '0;
      CLINT_awlen   = '0;
      CLINT_awsize  = '0;
      CLINT_awburst = '0;
      CLINT_wvalid  = 1'b0;
      CLINT_wdata   = '0;
      CLINT_wstrb   = '0;
      CLINT_wlast   = 1'b0;
      CLINT_bready  = 1'b0;
      CLINT_arvalid = 1'b0;
      CLINT_arid    = '0;
      CLINT_araddr  = '0;
      CLINT_arlen   = '0;
      CLINT_arsize  = '0;
      CLINT_arburst = '0;
      CLINT_rready  = 1'b0;
      MEM_awvalid   = 1'b0;
      MEM_awid      = '0;
      MEM_awaddr    = '0;
      MEM_awlen     = '0;
      MEM_awsize    = '0;
      MEM_awburst   = '0;
      MEM_wvalid    = 1'b0;
      MEM_wdata     = '0;
      MEM_wstrb     = '0;
      MEM_wlast     = 1'b0;
      MEM_bready    = 1'b0;
      MEM_arvalid   = 1'b0;
      MEM_arid      = '0;
      MEM_araddr    = '0;
      MEM_arlen     = '0;
      MEM_arsize    = '0;
      MEM_arburst   = '0;
      MEM_rready    = 1'b0;

      unique case (r_state)
         IDLE: begin
            CPU_awready = 1'b1;
            CPU_arready = ~CPU_awvalid;
            if (CPU_awvalid) begin
               w_next = (w_aw_tgt == TGT_ERR) ? W_ERR_DATA : W_ADDR;
            end else if (CPU_arvalid) begin
               w_next = (w_ar_tgt == TGT_ERR) ? R_ERR : R_ADDR;
            end
         end
         W_ADDR: begin
            if (w_to_clint) begin
               CLINT_awvalid = 1'b1;
               CLINT_awid    = r_id;
               CLINT_awaddr  = r_addr;
               CLINT_awlen   = r_len;
               CLINT_awsize  = r_size;
               CLINT_awburst = r_burst;
               if (CLINT_awready) w_next = W_DATA;
            end else begin
               MEM_awvalid = 1'b1;
               MEM_awid    = r_id;
               MEM_awaddr  = r_addr;
               MEM_awlen   = r_len;
               MEM_awsize  = r_size;
               MEM_awburst = r_burst;
               if (MEM_awready) w_next = W_DATA;
            end
         end
         W_DATA: begin
            if (w_to_clint) begin
               CLINT_wvalid = CPU_wvalid;
               CLINT_wdata  = CPU_wdata;
               CLINT_wstrb  = CPU_wstrb;
               CLINT_wlast  = CPU_wlast;
               CPU_wready   = CLINT_wready;
            end else begin
               MEM_wvalid = CPU_wvalid;
               MEM_wdata  = CPU_wdata;
               MEM_wstrb  = CPU_wstrb;
               MEM_wlast  = CPU_wlast;
               CPU_wready = MEM_wready;
            end
            if (CPU_wvalid && CPU_wready && CPU_wlast) w_next = W_RESP;
         end
         W_RESP: begin
            if (w_to_clint) begin
               CPU_bvalid   = CLINT_bvalid;
               CPU_bid      = CLINT_bid;
               CPU_bresp    = CLINT_bresp;
               CLINT_bready = CPU_bready;
            end else begin
               CPU_bvalid = MEM_bvalid;
               CPU_bid    = MEM_bid;
               CPU_bresp  = MEM_bresp;
               MEM_bready = CPU_bready;
            end
            if (CPU_bvalid && CPU_bready) w_next = IDLE;
         end
         W_ERR_DATA: begin
            CPU_wready = 1'b1;
            if (CPU_wvalid && CPU_wlast) w_next = W_ERR_RESP;
         end
         W_ERR_RESP: begin
            CPU_bvalid = 1'b1;
            CPU_bid    = r_id;
            CPU_bresp  = DECERR;
            if (CPU_bready) w_next = IDLE;
         end
         R_ADDR: begin
            if (w_to_clint) begin
               CLINT_arvalid = 1'b1;
               CLINT_arid    = r_id;
               CLINT_araddr  = r_addr;
               CLINT_arlen   = r_len;
               CLINT_arsize  = r_size;
               CLINT_arburst = r_burst;
               if (CLINT_arready) w_next = R_DATA;
            end else begin
               MEM_arvalid = 1'b1;
               MEM_arid    = r_id;
               MEM_araddr  = r_addr;
               MEM_arlen   = r_len;
               MEM_arsize  = r_size;
               MEM_arburst = r_burst;
               if (MEM_arready) w_next = R_DATA;
            end
         end
         R_DATA: begin
            if (w_to_clint) begin
               CPU_rvalid   = CLINT_rvalid;
               CPU_rid      = CLINT_rid;
               CPU_rresp    = CLINT_rresp;
               CPU_rdata    = CLINT_rdata;
               CPU_rlast    = CLINT_rlast;
               CLINT_rready = CPU_rready;
            end else begin
               CPU_rvalid = MEM_rvalid;
               CPU_rid    = MEM_rid;
               CPU_rresp  = MEM_rresp;
               CPU_rdata  = MEM_rdata;
               CPU_rlast  = MEM_rlast;
               MEM_rready = CPU_rready;
            end
            if (CPU_rvalid && CPU_rready && CPU_rlast) w_next = IDLE;
         end
         R_ERR: begin
            CPU_rvalid = 1'b1;
            CPU_rid    = r_id;
            CPU_rresp  = DECERR;
            CPU_rlast  = (r_cnt == 8'd0);
            if (CPU_rready && (r_cnt == 8'd0)) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_ysyx_041461_axi_demux.sv
// Directed bench for the CLINT/memory AXI router: forwarding, DECERR paths,
// AW/AR arbitration and mid-transaction reset.
module tb_ysyx_041461_axi_demux;

   logic        clk = 1'b0;
   logic        rst;
   logic        CPU_awvalid, CPU_awready, CPU_wvalid, CPU_wready, CPU_wlast;
   logic [3:0]  CPU_awid, CPU_bid, CPU_arid, CPU_rid;
   logic [31:0] CPU_awaddr, CPU_araddr;
   logic [7:0]  CPU_awlen, CPU_arlen, CPU_wstrb;
   logic [2:0]  CPU_awsize, CPU_arsize;
   logic [1:0]  CPU_awburst, CPU_arburst, CPU_bresp, CPU_rresp;
   logic [63:0] CPU_wdata, CPU_rdata;
   logic        CPU_bready, CPU_bvalid, CPU_arvalid, CPU_arready, CPU_rready, CPU_rvalid, CPU_rlast;

   logic        CLINT_awvalid, CLINT_awready, CLINT_wvalid, CLINT_wready, CLINT_wlast;
   logic [3:0]  CLINT_awid, CLINT_bid, CLINT_arid, CLINT_rid;
   logic [31:0] CLINT_awaddr, CLINT_araddr;
   logic [7:0]  CLINT_awlen, CLINT_arlen, CLINT_wstrb;
   logic [2:0]  CLINT_awsize, CLINT_arsize;
   logic [1:0]  CLINT_awburst, CLINT_arburst, CLINT_bresp, CLINT_rresp;
   logic [63:0] CLINT_wdata, CLINT_rdata;
   logic        CLINT_bready, CLINT_bvalid, CLINT_arvalid, CLINT_arready, CLINT_rready, CLINT_rvalid, CLINT_rlast;

   logic        MEM_awvalid, MEM_awready, MEM_wvalid, MEM_wready, MEM_wlast;
   logic [3:0]  MEM_awid, MEM_bid, MEM_arid, MEM_rid;
   logic [31:0] MEM_awaddr, MEM_araddr;
   logic [7:0]  MEM_awlen, MEM_arlen, MEM_wstrb;
   logic [2:0]  MEM_awsize, MEM_arsize;
   logic [1:0]  MEM_awburst, MEM_arburst, MEM_bresp, MEM_rresp;
   logic [63:0] MEM_wdata, MEM_rdata;
   logic        MEM_bready, MEM_bvalid, MEM_arvalid, MEM_arready, MEM_rready, MEM_rvalid, MEM_rlast;

   int n_vec = 0;
   int n_err = 0;

   ysyx_041461_axi_demux dut (
      .clk(clk), .rst(rst),
      .CPU_awvalid(CPU_awvalid), .CPU_awready(CPU_awready), .CPU_awid(CPU_awid),
      .CPU_awaddr(CPU_awaddr), .CPU_awlen(CPU_awlen), .CPU_awsize(CPU_awsize), .CPU_awburst(CPU_awburst),
      .CPU_wvalid(CPU_wvalid), .CPU_wready(CPU_wready), .CPU_wdata(CPU_wdata), .CPU_wstrb(CPU_wstrb),
      .CPU_wlast(CPU_wlast), .CPU_bready(CPU_bready), .CPU_bvalid(CPU_bvalid), .CPU_bid(CPU_bid),
      .CPU_bresp(CPU_bresp), .CPU_arvalid(CPU_arvalid), .CPU_arready(CPU_arready), .CPU_arid(CPU_arid),
      .CPU_araddr(CPU_araddr), .CPU_arlen(CPU_arlen), .CPU_arsize(CPU_arsize), .CPU_arburst(CPU_arburst),
      .CPU_rready(CPU_rready), .CPU_rvalid(CPU_rvalid), .CPU_rid(CPU_rid), .CPU_rresp(CPU_rresp),
      .CPU_rdata(CPU_rdata), .CPU_rlast(CPU_rlast),
      .CLINT_awvalid(CLINT_awvalid), .CLINT_awready(CLINT_awready), .CLINT_awid(CLINT_awid),
      .CLINT_awaddr(CLINT_awaddr), .CLINT_awlen(CLINT_awlen), .CLINT_awsize(CLINT_awsize),
      .CLINT_awburst(CLINT_awburst), .CLINT_wvalid(CLINT_wvalid), .CLINT_wready(CLINT_wready),
      .CLINT_wdata(CLINT_wdata), .CLINT_wstrb(CLINT_wstrb), .CLINT_wlast(CLINT_wlast),
      .CLINT_bready(CLINT_bready), .CLINT_bvalid(CLINT_bvalid), .CLINT_bid(CLINT_bid),
      .CLINT_bresp(CLINT_bresp), .CLINT_arvalid(CLINT_arvalid), .CLINT_arready(CLINT_arready),
      .CLINT_arid(CLINT_arid), .CLINT_araddr(CLINT_araddr), .CLINT_arlen(CLINT_arlen),
      .CLINT_arsize(CLINT_arsize), .CLINT_arburst(CLINT_arburst), .CLINT_rready(CLINT_rready),
      .CLINT_rvalid(CLINT_rvalid), .CLINT_rid(CLINT_rid), .CLINT_rresp(CLINT_rresp),
      .CLINT_rdata(CLINT_rdata), .CLINT_rlast(CLINT_rlast),
      .MEM_awvalid(MEM_awvalid), .MEM_awready(MEM_awready), .MEM_awid(MEM_awid),
      .MEM_awaddr(MEM_awaddr), .MEM_awlen(MEM_awlen), .MEM_awsize(MEM_awsize),
      .MEM_awburst(MEM_awburst), .MEM_wvalid(MEM_wvalid), .MEM_wready(MEM_wready),
      .MEM_wdata(MEM_wdata), .MEM_wstrb(MEM_wstrb), .MEM_wlast(MEM_wlast),
      .MEM_bready(MEM_bready), .MEM_bvalid(MEM_bvalid), .MEM_bid(MEM_bid),
      .MEM_bresp(MEM_bresp), .MEM_arvalid(MEM_arvalid), .MEM_arready(MEM_arready),
      .MEM_arid(MEM_arid), .MEM_araddr(MEM_araddr), .MEM_arlen(MEM_arlen),
      .MEM_arsize(MEM_arsize), .MEM_arburst(MEM_arburst), .MEM_rready(MEM_rready),
      .MEM_rvalid(MEM_rvalid), .MEM_rid(MEM_rid), .MEM_rresp(MEM_rresp),
      .MEM_rdata(MEM_rdata), .MEM_rlast(MEM_rlast)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs change on the falling edge; outputs are checked 1 time unit later.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic clr();
      CPU_awvalid = 0; CPU_awid = 0; CPU_awaddr = 0; CPU_awlen = 0; CPU_awsize = 0; CPU_awburst = 0;
      CPU_wvalid = 0; CPU_wdata = 0; CPU_wstrb = 0; CPU_wlast = 0; CPU_bready = 0;
      CPU_arvalid = 0; CPU_arid = 0; CPU_araddr = 0; CPU_arlen = 0; CPU_arsize = 0; CPU_arburst = 0;
      CPU_rready = 0;
      CLINT_awready = 0; CLINT_wready = 0; CLINT_bvalid = 0; CLINT_bid = 0; CLINT_bresp = 0;
      CLINT_arready = 0; CLINT_rvalid = 0; CLINT_rid = 0; CLINT_rresp = 0; CLINT_rdata = 0; CLINT_rlast = 0;
      MEM_awready = 0; MEM_wready = 0; MEM_bvalid = 0; MEM_bid = 0; MEM_bresp = 0;
      MEM_arready = 0; MEM_rvalid = 0; MEM_rid = 0; MEM_rresp = 0; MEM_rdata = 0; MEM_rlast = 0;
   endtask

   initial begin
      clr();
      rst = 1;
      @(negedge clk);
      tick();
      rst = 0;
      #1;
      // Reset state
      check("rst_awready", CPU_awready, 1);
      check("rst_arready", CPU_arready, 1);
      check("rst_bvalid", CPU_bvalid, 0);
      check("rst_rvalid", CPU_rvalid, 0);
      check("rst_wready", CPU_wready, 0);
      check("rst_clint_awv", CLINT_awvalid, 0);
      check("rst_mem_arv", MEM_arvalid, 0);
      check("rst_rdata", CPU_rdata, 0);

      // CLINT write, single beat
      CPU_awvalid = 1; CPU_awid = 4'd3; CPU_awaddr = 32'h0200_4000; CPU_awsize = 3'd3; CPU_awburst = 2'd1;
      #1 check("w1_clint_awv_early", CLINT_awvalid, 0);
      tick();
      clr();
      #1;
      check("w1_clint_awv", CLINT_awvalid, 1);
      check("w1_clint_awaddr", CLINT_awaddr, 64'h0200_4000);
      check("w1_clint_awid", CLINT_awid, 3);
      check("w1_clint_awsize", CLINT_awsize, 3);
      check("w1_mem_awv", MEM_awvalid, 0);
      check("w1_cpu_awready", CPU_awready, 0);
      CLINT_awready = 1;
      tick();
      clr();
      CPU_wvalid = 1; CPU_wdata = 64'h100; CPU_wstrb = 8'hff; CPU_wlast = 1; CLINT_wready = 1;
      #1;
      check("w1_clint_wv", CLINT_wvalid, 1);
      check("w1_clint_wdata", CLINT_wdata, 64'h100);
      check("w1_clint_wstrb", CLINT_wstrb, 8'hff);
      check("w1_cpu_wready", CPU_wready, 1);
      check("w1_mem_wv", MEM_wvalid, 0);
      tick();
      clr();
      CLINT_bvalid = 1; CLINT_bid = 4'd3; CLINT_bresp = 2'b00; CPU_bready = 1;
      #1;
      check("w1_cpu_bvalid", CPU_bvalid, 1);
      check("w1_cpu_bid", CPU_bid, 3);
      check("w1_cpu_bresp", CPU_bresp, 0);
      check("w1_clint_bready", CLINT_bready, 1);
      check("w1_mem_bready", MEM_bready, 0);
      tick();
      clr();
      #1;
      check("w1_idle_awready", CPU_awready, 1);
      check("w1_idle_bvalid", CPU_bvalid, 0);

      // CLINT mtime read
      CPU_arvalid = 1; CPU_arid = 4'd2; CPU_araddr = 32'h0200_bff8; CPU_arsize = 3'd3;
      #1 check("r1_arready", CPU_arready, 1);
      tick();
      clr();
      CLINT_arready = 1;
      #1;
      check("r1_clint_arv", CLINT_arvalid, 1);
      check("r1_clint_araddr", CLINT_araddr, 64'h0200_bff8);
      check("r1_mem_arv", MEM_arvalid, 0);
      tick();
      clr();
      CLINT_rvalid = 1; CLINT_rid = 4'd2; CLINT_rdata = 64'h1234_5678_9abc_def0; CLINT_rlast = 1;
      CPU_rready = 1;
      #1;
      check("r1_cpu_rvalid", CPU_rvalid, 1);
      check("r1_cpu_rdata", CPU_rdata, 64'h1234_5678_9abc_def0);
      check("r1_cpu_rlast", CPU_rlast, 1);
      check("r1_cpu_rid", CPU_rid, 2);
      check("r1_clint_rready", CLINT_rready, 1);
      tick();
      clr();
      #1;
      check("r1_idle_arready", CPU_arready, 1);
      check("r1_idle_rvalid", CPU_rvalid, 0);

      // MEM burst read, 4 beats with a 2-cycle stall before beat 2
      CPU_arvalid = 1; CPU_arid = 4'd1; CPU_araddr = 32'h8000_0000; CPU_arlen = 8'd3; CPU_arburst = 2'd1;
      tick();
      clr();
      MEM_arready = 1;
      #1;
      check("r2_mem_arv", MEM_arvalid, 1);
      check("r2_mem_arlen", MEM_arlen, 3);
      check("r2_mem_arburst", MEM_arburst, 1);
      check("r2_clint_arv", CLINT_arvalid, 0);
      tick();
      clr();
      for (int b = 0; b < 4; b++) begin
         MEM_rvalid = 1; MEM_rid = 4'd1; MEM_rdata = 64'hA0 + 64'(b); MEM_rlast = (b == 3);
         if (b == 2) begin
            for (int s = 0; s < 2; s++) begin
               CPU_rready = 0;
               #1;
               check("r2_stall_mem_rready", MEM_rready, 0);
               check("r2_stall_rvalid", CPU_rvalid, 1);
               tick();
            end
         end
         CPU_rready = 1;
         #1;
         check("r2_rdata", CPU_rdata, 64'hA0 + 64'(b));
         check("r2_rlast", CPU_rlast, (b == 3) ? 64'd1 : 64'd0);
         check("r2_mem_rready", MEM_rready, 1);
         tick();
      end
      clr();
      #1 check("r2_idle_arready", CPU_arready, 1);

      // Unmapped read, 3 local DECERR beats
      CPU_arvalid = 1; CPU_arid = 4'd5; CPU_araddr = 32'h1000_0000; CPU_arlen = 8'd2;
      tick();
      clr();
      for (int b = 0; b < 3; b++) begin
         CPU_rready = 1;
         #1;
         check("r3_rvalid", CPU_rvalid, 1);
         check("r3_rdata", CPU_rdata, 0);
         check("r3_rresp", CPU_rresp, 2'b11);
         check("r3_rid", CPU_rid, 5);
         check("r3_rlast", CPU_rlast, (b == 2) ? 64'd1 : 64'd0);
         check("r3_clint_arv", CLINT_arvalid, 0);
         check("r3_mem_arv", MEM_arvalid, 0);
         tick();
      end
      clr();
      #1 check("r3_idle_arready", CPU_arready, 1);

      // Just past MEM_LIMIT is unmapped: one DECERR beat
      CPU_arvalid = 1; CPU_arid = 4'd9; CPU_araddr = 32'h8800_0000;
      tick();
      clr();
      #1;
      check("r4_rresp", CPU_rresp, 2'b11);
      check("r4_rlast", CPU_rlast, 1);
      check("r4_mem_arv", MEM_arvalid, 0);
      CPU_rready = 1;
      tick();
      clr();

      // Last memory doubleword is still a MEM hit
      CPU_arvalid = 1; CPU_arid = 4'd8; CPU_araddr = 32'h87ff_fff8;
      tick();
      clr();
      MEM_arready = 1;
      #1 check("r5_mem_arv", MEM_arvalid, 1);
      tick();
      clr();
      MEM_rvalid = 1; MEM_rid = 4'd8; MEM_rlast = 1; MEM_rdata = 64'h55; CPU_rready = 1;
      #1 check("r5_rdata", CPU_rdata, 64'h55);
      tick();
      clr();

      // CLINT burst write is rejected
      CPU_awvalid = 1; CPU_awid = 4'd4; CPU_awaddr = 32'h0200_4000; CPU_awlen = 8'd1;
      tick();
      clr();
      CPU_wvalid = 1; CPU_wdata = 64'hdead; CPU_wlast = 0;
      #1;
      check("w2_clint_awv", CLINT_awvalid, 0);
      check("w2_cpu_wready0", CPU_wready, 1);
      check("w2_clint_wv", CLINT_wvalid, 0);
      tick();
      CPU_wlast = 1;
      #1;
      check("w2_cpu_wready1", CPU_wready, 1);
      check("w2_clint_awv1", CLINT_awvalid, 0);
      tick();
      clr();
      #1;
      check("w2_bvalid", CPU_bvalid, 1);
      check("w2_bresp", CPU_bresp, 2'b11);
      check("w2_bid", CPU_bid, 4);
      tick();
      #1 check("w2_bvalid_hold", CPU_bvalid, 1);
      CPU_bready = 1;
      tick();
      clr();
      #1 check("w2_idle_awready", CPU_awready, 1);

      // Simultaneous AW and AR: write first, AR held off
      CPU_awvalid = 1; CPU_awid = 4'd6; CPU_awaddr = 32'h8000_0100;
      CPU_arvalid = 1; CPU_arid = 4'd7; CPU_araddr = 32'h8000_0200;
      #1;
      check("c_arready_blocked", CPU_arready, 0);
      check("c_awready", CPU_awready, 1);
      tick();
      CPU_awvalid = 0;
      MEM_awready = 1;
      #1;
      check("c_mem_awv", MEM_awvalid, 1);
      check("c_mem_awaddr", MEM_awaddr, 64'h8000_0100);
      check("c_mem_arv", MEM_arvalid, 0);
      check("c_arready_busy", CPU_arready, 0);
      tick();
      MEM_awready = 0;
      CPU_wvalid = 1; CPU_wdata = 64'hcafe; CPU_wstrb = 8'h0f; CPU_wlast = 1; MEM_wready = 1;
      #1 check("c_mem_wstrb", MEM_wstrb, 8'h0f);
      tick();
      CPU_wvalid = 0; MEM_wready = 0;
      MEM_bvalid = 1; MEM_bid = 4'd6; MEM_bresp = 2'b00; CPU_bready = 1;
      #1 check("c_bid", CPU_bid, 6);
      tick();
      MEM_bvalid = 0; CPU_bready = 0;
      #1 check("c_arready_after", CPU_arready, 1);
      tick();
      CPU_arvalid = 0;
      MEM_arready = 1;
      #1 check("c_mem_araddr", MEM_araddr, 64'h8000_0200);
      tick();
      clr();
      MEM_rvalid = 1; MEM_rid = 4'd7; MEM_rlast = 1; MEM_rresp = 2'b00; CPU_rready = 1;
      #1 check("c_rid", CPU_rid, 7);
      tick();
      clr();
      #1 check("c_idle", CPU_awready, 1);

      // Reset while in W_DATA
      CPU_awvalid = 1; CPU_awid = 4'd2; CPU_awaddr = 32'h8000_0040;
      tick();
      clr();
      MEM_awready = 1;
      tick();
      clr();
      CPU_wvalid = 1; CPU_wlast = 0; MEM_wready = 1;
      #1 check("x_mem_wv_before", MEM_wvalid, 1);
      rst = 1;
      tick();
      rst = 0;
      #1;
      check("x_awready", CPU_awready, 1);
      check("x_mem_wv", MEM_wvalid, 0);
      check("x_clint_wv", CLINT_wvalid, 0);
      check("x_mem_awv", MEM_awvalid, 0);
      check("x_cpu_wready", CPU_wready, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ysyx_041461_axi_demux.md
Name: ysyx_041461_axi_demux

Overview:
Single-master, two-slave AXI4 router that sits between the core's memory port and its two targets: the CLINT (mtime/mtimecmp) and main memory.
- Decodes each AW/AR address and forwards the transaction to the matching target.
- Unmapped or illegal requests are completed locally with DECERR.
- One outstanding transaction at a time.
- Address and control are registered once; data and response channels are muxed combinationally.

Parameters:
CLINT_CMP_BASE, 32'h0200_4000, mtimecmp window base; window is 8 bytes.
CLINT_TIME_BASE, 32'h0200_bff8, mtime window base; window is 8 bytes.
MEM_BASE, 32'h8000_0000, main memory base.
MEM_LIMIT, 32'h87ff_ffff, main memory last byte address (inclusive).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
CPU_aw{valid,ready,id,addr,len,size,burst}  in/out(ready)  1,1,4,32,8,3,2  upstream write address
CPU_w{valid,ready,data,strb,last}  in/out(ready)  1,1,64,8,1  upstream write data
CPU_b{ready,valid,id,resp}  in/out  1,1,4,2  upstream write response
CPU_ar{valid,ready,id,addr,len,size,burst}  in/out(ready)  1,1,4,32,8,3,2  upstream read address
CPU_r{ready,valid,id,resp,data,last}  in/out  1,1,4,2,64,1  upstream read data
CLINT_aw*, CLINT_w*, CLINT_b*, CLINT_ar*, CLINT_r*  mirrored  same widths  CLINT master side
MEM_aw*, MEM_w*, MEM_b*, MEM_ar*, MEM_r*  mirrored  same widths  memory master side

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high. Asserting rst returns the FSM to IDLE on the next edge, including mid-transaction, and clears all captured registers to 0.
- FSM states: IDLE, W_ADDR, W_DATA, W_RESP, W_ERR_DATA, W_ERR_RESP, R_ADDR, R_DATA, R_ERR.
- Outputs out of reset:
  - CPU_awready=1 and CPU_arready=1 (IDLE).
  - Every other valid/ready output is 0; all id/data/resp outputs are 0.
- Decode, performed on the address and len:
  - CLINT hit: addr within either 8-byte window and len==0. A CLINT-window address with len!=0 → DECERR, because the CLINT never accepts bursts.
  - MEM hit: MEM_BASE<=addr<=MEM_LIMIT, any len.
  - Anything else → DECERR.
- IDLE:
  - CPU_awready=1; CPU_arready=~CPU_awvalid, so a write wins when AW and AR arrive in the same cycle and AR is held off.
  - On an AW handshake, capture id/addr/len/size/burst and the target. Next state: W_ADDR, or W_ERR_DATA on DECERR.
  - On an AR handshake, capture the same fields. Next state: R_ADDR, or R_ERR on DECERR (beat counter loaded with len).
- W_ADDR: drive the target's aw* from the captured registers with awvalid=1; the other target's awvalid stays 0. On target awready → W_DATA. AW therefore reaches the target 1 cycle after acceptance.
- W_DATA:
  - Forward CPU w* to the target; target wvalid = CPU_wvalid; CPU_wready = target wready.
  - On wvalid&wready&wlast → W_RESP.
- W_RESP: forward target b* to CPU; target bready = CPU_bready. On bvalid&bready → IDLE.
- W_ERR_DATA: CPU_wready=1 and all beats are discarded. On wvalid&wlast → W_ERR_RESP.
- W_ERR_RESP: CPU_bvalid=1, bid = captured id, bresp=2'b11. On CPU_bready → IDLE.
- R_ADDR: drive the target's ar* from the registers with arvalid=1. On target arready → R_DATA.
- R_DATA: forward target r* to CPU; target rready = CPU_rready. On rvalid&rready&rlast → IDLE.
- R_ERR:
  - CPU_rvalid=1, rdata=0, rresp=2'b11, rid = captured id; rlast=1 when the counter is 0.
  - Each rready decrements the counter; rready with counter 0 → IDLE.
  - len=255 produces 256 beats with no wrap.
- The non-selected target always sees valid=0 and ready=0. CPU outputs in states that do not own a channel are 0, except the ready signals driven in IDLE.
- The demux never reorders or merges beats, and never modifies strb, data or resp on forwarded traffic.

Decomposition:
- Shared package ysyx_041461_axi_pkg holds:
  - state encodings;
  - resp codes OKAY=2'b00 and DECERR=2'b11;
  - target select codes TGT_CLINT, TGT_MEM, TGT_ERR;
  - address-map defaults.
- One natural sub-module: ysyx_041461_axi_addr_decode, purely combinational (addr, len → target). It is instantiated twice, once for AW and once for AR.

Test Plan:
- AW 0x0200_4000 len0 size3, W 0x0000_0000_0000_0100 last → CLINT_awvalid 1 cycle after CPU handshake; CLINT_wdata 0x100; CPU_bresp=00 with matching id; MEM_* valids stay 0.
- AR 0x0200_bff8 len0 → CLINT_arvalid asserted; CPU_rdata equals CLINT_rdata, rlast=1; back to IDLE after rready.
- AR 0x8000_0000 len3 burst INCR → 4 MEM beats forwarded, rlast only on the 4th; rready held low for 2 cycles mid-burst stalls MEM_rready as well.
- AR 0x1000_0000 len2 id5 → 3 local beats, rdata=0, rresp=11, rid=5, rlast on beat 3; CLINT_arvalid and MEM_arvalid both stay 0.
- AW 0x0200_4000 len1 → W beats sunk, CPU_bresp=11; CLINT_awvalid never asserted.
- AW and AR valid in the same cycle → write serviced first, arready=0 that cycle; read completes afterwards. rst asserted in W_DATA → next cycle IDLE, all target valids 0, CPU_awready=1.
